// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared encodings for the front-end hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int          REG_W_DEFAULT = 5;
  localparam int          CNT_W         = 3;
  localparam logic [31:0] NOP_INSTR     = 32'h5400_0000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    FLUSH     = 2'd2,
    IMEM_WAIT = 2'd3
  } ctrl_state_t;

  // Per-cycle resolved action; outputs and next state both decode from this.
  typedef enum logic [2:0] {
    ACT_NORMAL = 3'd0,
    ACT_BRANCH = 3'd1,
    ACT_STALL  = 3'd2,
    ACT_WAIT   = 3'd3,
    ACT_FLUSH  = 3'd4
  } hz_act_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Pipeline <-> hazard controller signal bundle. Counter outputs
//            exist only when HAZARD_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
  #(parameter int REG_W = REG_W_DEFAULT)
  ();

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             branch_taken;
  logic             imem_ready;
  logic             pc_write;
  logic             hold_IF_ID;
  logic             IF_Flush;
  logic             id_ex_flush;
  logic [1:0]       ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]      stall_cycles;
  logic [15:0]      flush_cycles;
  logic [15:0]      imem_wait_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    input  pc_write, hold_IF_ID, IF_Flush, id_ex_flush, ctrl_state,
           stall_cycles, flush_cycles, imem_wait_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    output pc_write, hold_IF_ID, IF_Flush, id_ex_flush, ctrl_state,
           stall_cycles, flush_cycles, imem_wait_cycles
  );
`else
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    input  pc_write, hold_IF_ID, IF_Flush, id_ex_flush, ctrl_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           branch_taken, imem_ready,
    output pc_write, hold_IF_ID, IF_Flush, id_ex_flush, ctrl_state
  );
`endif

endinterface

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : Load-use hazard comparator between the ID sources and EX load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use_rs1,
  input  logic             i_use_rs2,
  input  logic             i_mem_read,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_luh
);

  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign o_luh = i_mem_read & (i_rd != '0) &
                 ((i_use_rs1 & (i_rs1 == i_rd)) | (i_use_rs2 & (i_rs2 == i_rd)));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Front-end flush/stall/freeze sequencer. Optional performance
//            counters enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W          = REG_W_DEFAULT,
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_CYCLES   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] c_FLUSH_RELOAD =
    CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] c_STALL_RELOAD =
    CNT_W'((LOAD_USE_STALL > 1) ? LOAD_USE_STALL - 2 : 0);

  ctrl_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_luh;
  hz_act_t          w_act;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .i_rs1      (bus.id_rs1),
    .i_rs2      (bus.id_rs2),
    .i_use_rs1  (bus.id_use_rs1),
    .i_use_rs2  (bus.id_use_rs2),
    .i_mem_read (bus.ex_mem_read),
    .i_rd       (bus.ex_rd),
    .o_luh      (w_luh)
  );

  // IMEM_WAIT resolves like RUN so a ready cycle fetches immediately.
  always_comb begin
    w_act = ACT_NORMAL;
    case (r_state)
      FLUSH:    w_act = bus.branch_taken ? ACT_BRANCH : ACT_FLUSH;
      LU_STALL: w_act = bus.branch_taken ? ACT_BRANCH : ACT_STALL;
      default: begin
        if (bus.branch_taken)     w_act = ACT_BRANCH;
        else if (w_luh)           w_act = ACT_STALL;
        else if (!bus.imem_ready) w_act = ACT_WAIT;
        else                      w_act = ACT_NORMAL;
      end
    endcase
  end

  always_comb begin
    if (rst) begin
      bus.pc_write    = 1'b0;
      bus.hold_IF_ID  = 1'b0;
      bus.IF_Flush    = 1'b1;
      bus.id_ex_flush = 1'b1;
      bus.ctrl_state  = RUN;
    end else begin
      bus.pc_write    = (w_act == ACT_NORMAL) || (w_act == ACT_BRANCH) || (w_act == ACT_FLUSH);
      bus.hold_IF_ID  = (w_act == ACT_STALL) || (w_act == ACT_WAIT);
      bus.IF_Flush    = (w_act == ACT_BRANCH) || (w_act == ACT_FLUSH);
      bus.id_ex_flush = (w_act != ACT_NORMAL);
      bus.ctrl_state  = r_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (w_act)
        ACT_BRANCH: begin
          if (FLUSH_CYCLES > 1) begin
            r_state <= FLUSH;
            r_cnt   <= c_FLUSH_RELOAD;
          end else begin
            r_state <= RUN;
          end
        end
        ACT_STALL: begin
          if (r_state == LU_STALL) begin
            if (r_cnt == '0) r_state <= RUN;
            else             r_cnt   <= r_cnt - 1'b1;
          end else if (LOAD_USE_STALL > 1) begin
            r_state <= LU_STALL;
            r_cnt   <= c_STALL_RELOAD;
          end else begin
            r_state <= RUN;
          end
        end
        ACT_FLUSH: begin
          if (r_cnt == '0) r_state <= RUN;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ACT_WAIT: r_state <= IMEM_WAIT;
        default:  r_state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_cycles;
  logic [15:0] r_imem_wait_cycles;
  logic        w_wait_cycle;

  assign w_wait_cycle = (r_state == IMEM_WAIT) || ((r_state == RUN) && !bus.imem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles     <= '0;
      r_flush_cycles     <= '0;
      r_imem_wait_cycles <= '0;
    end else begin
      if ((w_act == ACT_STALL) && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (((w_act == ACT_BRANCH) || (w_act == ACT_FLUSH)) && (r_flush_cycles != 16'hFFFF))
        r_flush_cycles <= r_flush_cycles + 16'd1;
      if (w_wait_cycle && (r_imem_wait_cycles != 16'hFFFF))
        r_imem_wait_cycles <= r_imem_wait_cycles + 16'd1;
    end
  end

  assign bus.stall_cycles     = r_stall_cycles;
  assign bus.flush_cycles     = r_flush_cycles;
  assign bus.imem_wait_cycles = r_imem_wait_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Scoreboard bench driving two controller configurations in step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic s_use1, s_use2, s_mr, s_br, s_rdy;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  typedef struct {
    int          step;
    logic [5:0]  exp_a;
    logic [5:0]  exp_b;
    bit          perf_chk;
    logic [15:0] perf_a;
    logic [15:0] perf_b;
  } sb_t;

  sb_t sb_q[$];

  // Output nibble order: {pc_write, hold_IF_ID, IF_Flush, id_ex_flush}
  localparam logic [3:0] c_N  = 4'b1000;
  localparam logic [3:0] c_RS = 4'b0011;
  localparam logic [3:0] c_ST = 4'b0101;
  localparam logic [3:0] c_FL = 4'b1011;

  pipeline_hazard_ctrl_if #(.REG_W(5)) if_a ();
  pipeline_hazard_ctrl_if #(.REG_W(5)) if_b ();

  pipeline_hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(1), .FLUSH_CYCLES(2)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  pipeline_hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(3), .FLUSH_CYCLES(1)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b)
  );

  assign if_a.id_rs1 = s_rs1;        assign if_b.id_rs1 = s_rs1;
  assign if_a.id_rs2 = s_rs2;        assign if_b.id_rs2 = s_rs2;
  assign if_a.id_use_rs1 = s_use1;   assign if_b.id_use_rs1 = s_use1;
  assign if_a.id_use_rs2 = s_use2;   assign if_b.id_use_rs2 = s_use2;
  assign if_a.ex_mem_read = s_mr;    assign if_b.ex_mem_read = s_mr;
  assign if_a.ex_rd = s_rd;          assign if_b.ex_rd = s_rd;
  assign if_a.branch_taken = s_br;   assign if_b.branch_taken = s_br;
  assign if_a.imem_ready = s_rdy;    assign if_b.imem_ready = s_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ov(input logic [1:0] st, input logic [3:0] o);
    return {st, o};
  endfunction

  task automatic drive(input logic r, input logic br, input logic rdy, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [5:0] ea, input logic [5:0] eb,
                       input bit pchk = 1'b0, input logic [15:0] pa = '0,
                       input logic [15:0] pb = '0);
    sb_t e;
    @(posedge clk);
    #1;
    rst = r; s_br = br; s_rdy = rdy; s_mr = mr; s_rd = rd;
    s_rs1 = rs1; s_use1 = u1; s_rs2 = rs2; s_use2 = u2;
    step_no++;
    e.step = step_no; e.exp_a = ea; e.exp_b = eb;
    e.perf_chk = pchk; e.perf_a = pa; e.perf_b = pb;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [5:0] ea, input logic [5:0] eb);
    drive(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ea, eb);
  endtask

  // Load to x5 consumed via rs2 of the ID instruction.
  task automatic luh(input logic br, input logic rdy, input logic [5:0] ea, input logic [5:0] eb);
    drive(0, br, rdy, 1, 5'd5, 5'd0, 0, 5'd5, 1, ea, eb);
  endtask

  // Monitor: compare on the falling edge, half a cycle after stimulus.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      logic [5:0] act_a, act_b;
      e = sb_q.pop_front();
      act_a = {if_a.ctrl_state, if_a.pc_write, if_a.hold_IF_ID, if_a.IF_Flush, if_a.id_ex_flush};
      act_b = {if_b.ctrl_state, if_b.pc_write, if_b.hold_IF_ID, if_b.IF_Flush, if_b.id_ex_flush};
      checks++;
      if (act_a !== e.exp_a) begin
        failures++;
        $display("FAIL step%0d dut_a {state,pc,hold,iff,idex}: got %b want %b", e.step, act_a, e.exp_a);
      end
      checks++;
      if (act_b !== e.exp_b) begin
        failures++;
        $display("FAIL step%0d dut_b {state,pc,hold,iff,idex}: got %b want %b", e.step, act_b, e.exp_b);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e.perf_chk) begin
        checks++;
        if (if_a.stall_cycles !== e.perf_a) begin
          failures++;
          $display("FAIL step%0d dut_a stall_cycles: got %0d want %0d", e.step, if_a.stall_cycles, e.perf_a);
        end
        checks++;
        if (if_b.stall_cycles !== e.perf_b) begin
          failures++;
          $display("FAIL step%0d dut_b stall_cycles: got %0d want %0d", e.step, if_b.stall_cycles, e.perf_b);
        end
      end
`endif
    end
  end

  initial begin
    int waited;
    rst = 1'b1; s_br = 0; s_rdy = 1; s_mr = 0; s_rd = 0;
    s_rs1 = 0; s_use1 = 0; s_rs2 = 0; s_use2 = 0;

    // Reset held three cycles, then normal RUN
    repeat (3) drive(1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_RS), ov(0, c_RS));
    drive(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_N), ov(0, c_N), 1'b1, 16'd0, 16'd0);

    // Load-use on rs2: A stalls once, B stalls three cycles
    luh(0, 1, ov(0, c_ST), ov(0, c_ST));
    idle(ov(0, c_N), ov(1, c_ST));
    idle(ov(0, c_N), ov(1, c_ST));
    drive(0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_N), ov(0, c_N), 1'b1, 16'd1, 16'd3);

    // Non-hazards: rd=x0, rs1 match unused, not a load
    drive(0, 0, 1, 1, 5'd0, 5'd0, 0, 5'd0, 1, ov(0, c_N), ov(0, c_N));
    drive(0, 0, 1, 1, 5'd7, 5'd7, 0, 5'd0, 0, ov(0, c_N), ov(0, c_N));
    drive(0, 0, 1, 0, 5'd7, 5'd7, 1, 5'd0, 0, ov(0, c_N), ov(0, c_N));

    // Hazard through rs1
    drive(0, 0, 1, 1, 5'd7, 5'd7, 1, 5'd0, 0, ov(0, c_ST), ov(0, c_ST));
    idle(ov(0, c_N), ov(1, c_ST));
    idle(ov(0, c_N), ov(1, c_ST));
    idle(ov(0, c_N), ov(0, c_N));

    // Branch: A flushes two cycles, B one
    drive(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_FL), ov(0, c_FL));
    idle(ov(2, c_FL), ov(0, c_N));
    idle(ov(0, c_N), ov(0, c_N));

    // Branch and load-use together: flush wins
    luh(1, 1, ov(0, c_FL), ov(0, c_FL));
    idle(ov(2, c_FL), ov(0, c_N));

    // Instruction memory not ready for four cycles
    drive(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_ST), ov(0, c_ST));
    repeat (3) drive(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(3, c_ST), ov(3, c_ST));
    idle(ov(3, c_N), ov(3, c_N));
    idle(ov(0, c_N), ov(0, c_N));

    // Reset mid-stall in B
    luh(0, 1, ov(0, c_ST), ov(0, c_ST));
    drive(1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_RS), ov(0, c_RS));
    idle(ov(0, c_N), ov(0, c_N));

    // Branch preempts an ongoing load-use stall
    luh(0, 1, ov(0, c_ST), ov(0, c_ST));
    drive(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_FL), ov(1, c_FL));
    idle(ov(2, c_FL), ov(0, c_N));
    idle(ov(0, c_N), ov(0, c_N));

    // Branch preempts an imem wait
    drive(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_ST), ov(0, c_ST));
    drive(0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(3, c_FL), ov(3, c_FL));
    idle(ov(2, c_FL), ov(0, c_N));
    idle(ov(0, c_N), ov(0, c_N));

    // Back-to-back branches reload the flush window in A
    drive(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_FL), ov(0, c_FL));
    drive(0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(2, c_FL), ov(0, c_FL));
    idle(ov(2, c_FL), ov(0, c_N));
    idle(ov(0, c_N), ov(0, c_N));

    // Load-use outranks a pending imem wait
    drive(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ov(0, c_ST), ov(0, c_ST));
    luh(0, 0, ov(3, c_ST), ov(3, c_ST));
    idle(ov(0, c_N), ov(1, c_ST));
    idle(ov(0, c_N), ov(1, c_ST));
    idle(ov(0, c_N), ov(0, c_N));

    waited = 0;
    while (sb_q.size() != 0 && waited < 5) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d scoreboard entries left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the front end of the 5-stage core. Drives PC write-enable and the IF/ID register's hold_IF_ID / IF_Flush inputs, plus the ID/EX bubble.
- Resolves taken branches (flush), load-use hazards (stall plus bubble) and instruction-memory wait states (freeze).
- A small FSM stretches stalls and flushes over multiple cycles.

Parameters:
- REG_W, 5, register-specifier width.
- LOAD_USE_STALL, 1, number of stall cycles per load-use hazard (1..7).
- FLUSH_CYCLES, 1, number of cycles IF_Flush stays asserted after a taken branch (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_rs1  in  REG_W  source register 1 of the instruction in ID
- id_rs2  in  REG_W  source register 2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the instruction in EX
- branch_taken  in  1  EX resolved a taken branch this cycle
- imem_ready  in  1  instruction memory data valid this cycle
- pc_write  out  1  PC register load enable
- hold_IF_ID  out  1  freeze the IF/ID register
- IF_Flush  out  1  load NOP 0x54000000 into IF/ID
- id_ex_flush  out  1  insert a bubble into ID/EX
- ctrl_state  out  2  current FSM state, for debug

Behaviour:
- Reset is synchronous, active-high, on rst with clock clk.
  - While rst=1: pc_write=0, hold_IF_ID=0, IF_Flush=1, id_ex_flush=1, state=RUN, counter=0.
  - First cycle after reset: normal RUN outputs.
- FSM states (ctrl_state encoding): RUN=0, LU_STALL=1, FLUSH=2, IMEM_WAIT=3. A 3-bit down-counter cnt is shared by the multi-cycle states.
- Outputs are combinational from state and inputs, so they act in the same cycle. Only state and cnt are registered.
- Load-use hazard: luh = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority inside any state: branch_taken > luh > !imem_ready > normal.
- RUN:
  - branch_taken: pc_write=1 (target load), IF_Flush=1, id_ex_flush=1, hold_IF_ID=0. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2.
  - luh: pc_write=0, hold_IF_ID=1, id_ex_flush=1, IF_Flush=0. If LOAD_USE_STALL>1, go to LU_STALL with cnt=LOAD_USE_STALL-2.
  - !imem_ready: pc_write=0, hold_IF_ID=1, id_ex_flush=1. Go to IMEM_WAIT.
  - Otherwise: pc_write=1, all other outputs 0.
- LU_STALL: same outputs as the luh case. Decrement cnt; when cnt==0, return to RUN. A branch_taken arriving here preempts the stall and takes the RUN branch actions and transition.
- FLUSH: pc_write=1, IF_Flush=1, id_ex_flush=1. Decrement cnt; when cnt==0, return to RUN. A new branch_taken reloads cnt=FLUSH_CYCLES-2 (or returns to RUN if FLUSH_CYCLES==1).
- IMEM_WAIT: pc_write=0, hold_IF_ID=1, id_ex_flush=1, IF_Flush=0.
  - imem_ready=1: return to RUN and apply RUN rules on the next cycle.
  - branch_taken: preempts, with the RUN branch actions.
- IF_Flush and hold_IF_ID are never both 1. ex_rd==0 never causes a stall.
- Reset asserted mid-stall or mid-flush aborts immediately to the reset values.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three 16-bit saturating outputs, cleared on rst:
  - stall_cycles: increments each cycle with hold_IF_ID=1 due to luh.
  - flush_cycles: increments each cycle with IF_Flush=1, excluding reset.
  - imem_wait_cycles: increments each IMEM_WAIT or RUN!imem_ready cycle.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/header pipe_ctrl_pkg: state encodings RUN/LU_STALL/FLUSH/IMEM_WAIT, NOP_INSTR=32'h54000000, REG_W default.
- Optional sub-module hazard_detect: the combinational luh comparator, reusable by the forwarding unit.
- The FSM and output logic stay in pipeline_hazard_ctrl.

Test Plan:
- Reset held 3 cycles -> IF_Flush=1, id_ex_flush=1, pc_write=0, ctrl_state=0. Release -> pc_write=1, others 0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1, LOAD_USE_STALL=1 -> one cycle of hold_IF_ID=1, pc_write=0, id_ex_flush=1, then pc_write=1. Same stimulus with ex_rd=0 -> no stall.
- LOAD_USE_STALL=3 with the hazard held for one cycle -> exactly 3 stall cycles, ctrl_state=1 for cycles 2-3.
- branch_taken pulse, FLUSH_CYCLES=2 -> IF_Flush=1 for 2 cycles, pc_write=1 in both. branch_taken and luh in the same cycle -> flush wins, hold_IF_ID=0.
- imem_ready low for 4 cycles -> pc_write=0, hold_IF_ID=1 for 4 cycles, ctrl_state=3. Recovers to RUN the cycle after imem_ready=1.
- rst asserted during LU_STALL (cnt=1) -> next cycle shows reset values. With HAZARD_PERF_CNT_EN, counters read 0 after reset and stall_cycles=3 after the LOAD_USE_STALL=3 scenario.
